pcs_link_ctrl: RTL and testbench
================================

# pcs_link_ctrl

Link controller for the 1000BASE-X PCS receive path. Sequences the code-group synchronizer: holds it in reset after power-up or restart, waits for `sync_status`, qualifies the link with a stability timer, then enables downstream receive processing of `SUDI`. On loss of sync it drops the link and, if sync does not return within a timeout, re-resets the synchronizer.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `sync_reset` is held asserted per synchronizer reset (≥1).
- `LINK_TIMER`, 16: consecutive cycles `sync_status` must stay high before link-up (≥1).
- `RESYNC_TIMEOUT`, 64: cycles allowed in WAIT_SYNC before the synchronizer is re-reset (≥1).
- `CNT_W`, 8: width of the internal timer counter; must hold max(`RST_CYCLES`, `LINK_TIMER`, `RESYNC_TIMEOUT`) − 1.

Ports:
- `clk` in 1: PCS receive clock.
- `reset` in 1: asynchronous, active-low reset.
- `sync_status` in 1: synchronizer lock indication.
- `SUDI` in 11: `[10]` = rx_even, `[9:0]` = rx_code_group.
- `restart` in 1: single-cycle request to restart link bring-up.
- `sync_reset` out 1: active-low reset to the synchronizer.
- `link_up` out 1: link qualified.
- `rx_enable` out 1: downstream receive-FSM enable, even-aligned.
- `state` out 2: current FSM state, for debug.
- `loss_cnt` out 8: loss-of-sync event count (`LINK_STATS_EN` only).

## Operation
- State encoding: RESET_SYNC=0, WAIT_SYNC=1, LINK_TIMER=2, LINK_UP=3.
- RESET_SYNC: `sync_reset`=0. Timer counts 0..`RST_CYCLES`−1, then → WAIT_SYNC with timer cleared.
- WAIT_SYNC: `sync_status`=1 → LINK_TIMER with timer cleared. Otherwise the timer increments; at `RESYNC_TIMEOUT`−1 → RESET_SYNC.
- LINK_TIMER: `sync_status`=0 → WAIT_SYNC with timer cleared. Timer at `LINK_TIMER`−1 with `sync_status`=1 → LINK_UP.
- LINK_UP: `link_up`=1. `rx_enable` sets on the first cycle in LINK_UP with `SUDI[10]`=1 and stays set while in LINK_UP. `sync_status`=0 → WAIT_SYNC, clearing `link_up` and `rx_enable`.
- `restart`=1 in any state → RESET_SYNC with timer cleared. Restart has priority over every other transition.
- If sync drops on the same cycle the link timer expires, the FSM goes to WAIT_SYNC, not LINK_UP.
- A `restart` pulse during RESET_SYNC restarts the full `RST_CYCLES` hold.

## Timing
- All outputs are registered and Moore-style from the state and flag registers. There is no combinational input-to-output path.
- Reset values: state=RESET_SYNC, `sync_reset`=0, `link_up`=0, `rx_enable`=0, `loss_cnt`=0, timer=0.
- After `reset` deasserts, `sync_reset` stays low for exactly `RST_CYCLES` rising edges, then goes high.
- Link-up latency: if `sync_status` is first sampled high at edge k and stays high, `link_up`=1 after edge k+`LINK_TIMER`.
- `rx_enable` rises one edge after `SUDI[10]` is sampled 1 in LINK_UP, at the earliest the edge after entry into LINK_UP.
- Loss of sync: `link_up` and `rx_enable` fall one edge after `sync_status` is sampled 0.
- Reset mid-operation: all registers go to reset values immediately (asynchronous), regardless of state.

## Configuration
- `PCS_LINK_STATS_EN` defined: `loss_cnt` port is present. It increments by 1 on each LINK_UP→WAIT_SYNC transition and saturates at 255.
  - Cleared only by `reset`; `restart` does not clear it.
  - A restart out of LINK_UP does not count as a loss.
- Not defined: `loss_cnt` port and its counter are absent.

## Structure
- Shared include `pcs_defines.vh` holds the state encodings (`PCS_LC_RESET_SYNC`, …) and the SUDI field positions (`SUDI_EVEN_BIT`=10).
- Sub-module `pcs_timer`: a `CNT_W`-bit up-counter with synchronous clear and an `expire` compare against a terminal value. It is instantiated once and shared by all three timed states, with the terminal value muxed by state.

## Test plan
- Power-up: release `reset`, `sync_status`=0 → `sync_reset` low for 4 cycles, high for 64 cycles (WAIT_SYNC), then low again for 4 cycles, repeating. `link_up` stays 0.
- Clean bring-up: `sync_status` high from cycle 10, `SUDI[10]` toggling → `link_up`=1 exactly 16 edges after the first high sample. `rx_enable` rises on the first even cycle after that.
- Glitch during qualification: `sync_status` drops at the 8th link-timer cycle → state returns to 1, `link_up` stays 0. Re-qualification needs the full 16 cycles.
- Loss in LINK_UP with stats: drop `sync_status` for 1 cycle three times → `link_up`/`rx_enable` fall each time, `loss_cnt`=3. A 300-event run saturates `loss_cnt` at 255.
- Restart priority: assert `restart` on the cycle the link timer expires → state=0, `sync_reset`=0 for 4 cycles, `loss_cnt` unchanged.
- Async reset mid-LINK_UP: assert `reset` between clock edges → `link_up`, `rx_enable`, `loss_cnt` are 0 and `sync_reset`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pcs_link_ctrl_pkg.sv
// Shared types and constants for the 1000BASE-X PCS receive link controller.
// State encodings and SUDI field positions used by pcs_link_ctrl and its bench.
package pcs_link_ctrl_pkg;

  typedef enum logic [1:0] {
    PCS_LC_RESET_SYNC = 2'd0,
    PCS_LC_WAIT_SYNC  = 2'd1,
    PCS_LC_LINK_TIMER = 2'd2,
    PCS_LC_LINK_UP    = 2'd3
  } pcs_lc_state_e;

  localparam int SUDI_W        = 11;
  localparam int SUDI_EVEN_BIT = 10;

  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

endpackage

// File: rtl/pcs_timer.sv
// Shared up-counter for the link controller's timed states.
// Synchronous clear; o_expire flags when the count equals the terminal value.
module pcs_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == i_term);

endmodule

// File: rtl/pcs_link_ctrl.sv
// 1000BASE-X PCS receive link controller: synchronizer reset, link qualification, rx enable.
// Define PCS_LINK_STATS_EN to add the saturating loss-of-sync counter and loss_cnt port.
//
// state       | meaning
// RESET_SYNC  | synchronizer held in reset for RST_CYCLES
// WAIT_SYNC   | waiting for sync_status; re-reset after RESYNC_TIMEOUT
// LINK_TIMER  | sync_status must hold for LINK_TIMER cycles
// LINK_UP     | link qualified; rx_enable arms on first even code-group
module pcs_link_ctrl
  import pcs_link_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int LINK_TIMER     = 16,
  parameter int RESYNC_TIMEOUT = 64,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_status,
  input  logic [SUDI_W-1:0] SUDI,
  input  logic              restart,
  output logic              sync_reset,
  output logic              link_up,
  output logic              rx_enable,
  output logic [1:0]        state
`ifdef PCS_LINK_STATS_EN
  ,
  output logic [7:0]        loss_cnt
`endif
);

  localparam logic [CNT_W-1:0] TERM_RST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TERM_RESYNC = CNT_W'(RESYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TERM_LINK   = CNT_W'(LINK_TIMER - 1);

  pcs_lc_state_e    r_state;
  pcs_lc_state_e    w_next_state;
  logic             r_rx_en;
  logic             w_tmr_clr;
  logic             w_expire;
  logic [CNT_W-1:0] w_term;
  logic             w_unused_code_group;

  // The code-group itself is consumed downstream; only rx_even matters here.
  assign w_unused_code_group = ^SUDI[SUDI_EVEN_BIT-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PCS_LC_RESET_SYNC;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (restart) begin
      w_next_state = PCS_LC_RESET_SYNC;
    end else begin
      case (r_state)
        PCS_LC_RESET_SYNC: if (w_expire) w_next_state = PCS_LC_WAIT_SYNC;
        PCS_LC_WAIT_SYNC: begin
          if (sync_status)   w_next_state = PCS_LC_LINK_TIMER;
          else if (w_expire) w_next_state = PCS_LC_RESET_SYNC;
        end
        PCS_LC_LINK_TIMER: begin
          if (!sync_status)  w_next_state = PCS_LC_WAIT_SYNC;
          else if (w_expire) w_next_state = PCS_LC_LINK_UP;
        end
        PCS_LC_LINK_UP:    if (!sync_status) w_next_state = PCS_LC_WAIT_SYNC;
        default:           w_next_state = PCS_LC_RESET_SYNC;
      endcase
    end
  end

  always_comb begin
    sync_reset = (r_state != PCS_LC_RESET_SYNC);
    link_up    = (r_state == PCS_LC_LINK_UP);
  end

  // Timer restarts on every state change and on restart (which re-arms the hold).
  assign w_tmr_clr = restart || (w_next_state != r_state) || (r_state == PCS_LC_LINK_UP);

  always_comb begin
    case (r_state)
      PCS_LC_RESET_SYNC: w_term = TERM_RST;
      PCS_LC_WAIT_SYNC:  w_term = TERM_RESYNC;
      PCS_LC_LINK_TIMER: w_term = TERM_LINK;
      default:           w_term = '0;
    endcase
  end

  pcs_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_clr    (w_tmr_clr),
    .i_term   (w_term),
    .o_expire (w_expire)
  );

  // rx_even seen on the entry edge does not count; must be sampled inside LINK_UP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_en <= 1'b0;
    end else begin
      r_rx_en <= (w_next_state == PCS_LC_LINK_UP) &&
                 (r_rx_en || ((r_state == PCS_LC_LINK_UP) && SUDI[SUDI_EVEN_BIT]));
    end
  end

  assign rx_enable = r_rx_en;
  assign state     = r_state;

`ifdef PCS_LINK_STATS_EN
  logic [7:0] r_loss_cnt;

  // Restart out of LINK_UP goes to RESET_SYNC, so it never counts as a loss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_loss_cnt <= 8'd0;
    end else if ((r_state == PCS_LC_LINK_UP) && (w_next_state == PCS_LC_WAIT_SYNC) &&
                 (r_loss_cnt != LOSS_CNT_MAX)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed table-driven bench for pcs_link_ctrl (default parameters).
// Loss-counter checks are compiled in when PCS_LINK_STATS_EN is defined.
module tb_pcs_link_ctrl;

  logic        clk;
  logic        reset;
  logic        sync_status;
  logic [10:0] SUDI;
  logic        restart;
  logic        sync_reset;
  logic        link_up;
  logic        rx_enable;
  logic [1:0]  state;
`ifdef PCS_LINK_STATS_EN
  logic [7:0]  loss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       sync;
    logic       even;
    logic       rst_req;
    int         n;
    logic [1:0] exp_state;
    logic       exp_sr;
    logic       exp_lu;
    logic       exp_rx;
    int         exp_loss;
  } vec_t;

  vec_t vq[$];

  pcs_link_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .sync_status (sync_status),
    .SUDI        (SUDI),
    .restart     (restart),
    .sync_reset  (sync_reset),
    .link_up     (link_up),
    .rx_enable   (rx_enable),
    .state       (state)
`ifdef PCS_LINK_STATS_EN
    ,
    .loss_cnt    (loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_loss(input string name, input int exp);
`ifdef PCS_LINK_STATS_EN
    chk(name, int'(loss_cnt), exp);
`endif
  endtask

  function automatic void add(input logic s, input logic e, input logic r, input int n,
                              input logic [1:0] st, input logic sr, input logic lu,
                              input logic rx, input int ls);
    vec_t v;
    v.sync = s; v.even = e; v.rst_req = r; v.n = n;
    v.exp_state = st; v.exp_sr = sr; v.exp_lu = lu; v.exp_rx = rx; v.exp_loss = ls;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic s, input logic e, input logic r, input int salt);
    logic [9:0] cg;
    cg = 10'(salt * 37);
    sync_status = s;
    SUDI        = {e, cg};
    restart     = r;
  endtask

  initial begin
    //   sync even rst   n  state sr lu rx loss
    add(0, 0, 0,  3, 2'd0, 0, 0, 0, 0);  // hold still in reset
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 0);  // released after exactly 4 edges
    add(0, 0, 0, 63, 2'd1, 1, 0, 0, 0);
    add(0, 0, 0,  1, 2'd0, 0, 0, 0, 0);  // 64th edge: resync timeout
    add(0, 0, 0,  4, 2'd1, 1, 0, 0, 0);
    add(1, 0, 0,  1, 2'd2, 1, 0, 0, 0);
    add(1, 1, 0,  7, 2'd2, 1, 0, 0, 0);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 0);  // glitch on 8th link-timer cycle
    add(1, 0, 0,  1, 2'd2, 1, 0, 0, 0);
    add(1, 0, 0, 15, 2'd2, 1, 0, 0, 0);
    add(1, 1, 0,  1, 2'd3, 1, 1, 0, 0);  // even on entry edge ignored
    add(1, 0, 0,  1, 2'd3, 1, 1, 0, 0);
    add(1, 1, 0,  1, 2'd3, 1, 1, 1, 0);
    add(1, 0, 0,  3, 2'd3, 1, 1, 1, 0);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 1);  // loss 1
    add(1, 0, 0, 17, 2'd3, 1, 1, 0, 1);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 2);  // loss 2
    add(1, 0, 0, 17, 2'd3, 1, 1, 0, 2);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 3);  // loss 3
    add(1, 0, 0, 16, 2'd2, 1, 0, 0, 3);
    add(1, 0, 1,  1, 2'd0, 0, 0, 0, 3);  // restart beats timer expiry
    add(0, 0, 0,  2, 2'd0, 0, 0, 0, 3);
    add(0, 0, 1,  1, 2'd0, 0, 0, 0, 3);  // restart inside RESET_SYNC
    add(0, 0, 0,  3, 2'd0, 0, 0, 0, 3);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 3);
    add(1, 0, 0, 17, 2'd3, 1, 1, 0, 3);
    add(1, 1, 1,  1, 2'd0, 0, 0, 0, 3);  // restart out of LINK_UP: no loss
    add(0, 0, 0,  4, 2'd1, 1, 0, 0, 3);
    add(1, 0, 0, 16, 2'd2, 1, 0, 0, 3);
    add(0, 0, 0,  1, 2'd1, 1, 0, 0, 3);  // drop on expiry edge -> WAIT_SYNC

    reset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst state", int'(state), 0);
    chk("rst sync_reset", int'(sync_reset), 0);
    chk("rst link_up", int'(link_up), 0);
    chk("rst rx_enable", int'(rx_enable), 0);
    chk_loss("rst loss_cnt", 0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sync, vq[i].even, vq[i].rst_req, i);
      repeat (vq[i].n) @(negedge clk);
      chk($sformatf("row%0d state", i), int'(state), int'(vq[i].exp_state));
      chk($sformatf("row%0d sync_reset", i), int'(sync_reset), int'(vq[i].exp_sr));
      chk($sformatf("row%0d link_up", i), int'(link_up), int'(vq[i].exp_lu));
      chk($sformatf("row%0d rx_enable", i), int'(rx_enable), int'(vq[i].exp_rx));
      chk_loss($sformatf("row%0d loss_cnt", i), vq[i].exp_loss);
    end

    // Async reset between edges while in LINK_UP with rx enabled
    drive(1, 0, 0, 7);
    repeat (17) @(negedge clk);
    drive(1, 1, 0, 8);
    @(negedge clk);
    chk("pre-areset link_up", int'(link_up), 1);
    chk("pre-areset rx_enable", int'(rx_enable), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset state", int'(state), 0);
    chk("areset sync_reset", int'(sync_reset), 0);
    chk("areset link_up", int'(link_up), 0);
    chk("areset rx_enable", int'(rx_enable), 0);
    chk_loss("areset loss_cnt", 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 9);
    repeat (4) @(negedge clk);
    chk("post-areset state", int'(state), 1);

`ifdef PCS_LINK_STATS_EN
    // 300 loss events: counter must saturate at 255
    for (int ev = 1; ev <= 300; ev++) begin
      drive(1, 0, 0, ev);
      repeat (17) @(negedge clk);
      drive(0, 0, 0, ev);
      @(negedge clk);
      if (ev == 254) chk("loss_cnt 254", int'(loss_cnt), 254);
      if (ev == 255) chk("loss_cnt 255", int'(loss_cnt), 255);
    end
    chk("loss_cnt saturated", int'(loss_cnt), 255);
    chk("sat state", int'(state), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
